// File: rtl/csa_add3_pipe.sv
// csa_add3_pipe: three-operand adder, carry-save stage then two-stage split CPA, global-stall valid/ready
module csa_add3_pipe #(
  parameter int WIDTH = 8,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum
);
  localparam int HW = WIDTH - LO_W;
  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_s1, r_c1;
  logic [LO_W-1:0]  r_lo;
  logic             r_k2;
  logic [HW-1:0]    r_s2h;
  logic [HW:0]      r_c2h;
  logic [WIDTH+1:0] r_sum;
  logic             w_en;
  logic [LO_W:0]    w_lo;
  logic [HW+1:0]    w_hi;
  assign w_en      = !r_v3 | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign sum       = r_sum;
  // carry word is weighted one bit up; its bit LO_W-1 crosses into the high slice
  assign w_lo = {1'b0, r_s1[LO_W-1:0]} + {1'b0, LO_W'({r_c1, 1'b0})};
  assign w_hi = {2'b0, r_s2h} + {1'b0, r_c2h} + {{(HW+1){1'b0}}, r_k2};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_s1  <= '0;
      r_c1  <= '0;
      r_lo  <= '0;
      r_k2  <= 1'b0;
      r_s2h <= '0;
      r_c2h <= '0;
      r_sum <= '0;
    end else if (w_en) begin
      r_v1  <= in_valid;
      r_v2  <= r_v1;
      r_v3  <= r_v2;
      r_s1  <= a ^ b ^ c;
      r_c1  <= (a & b) | (a & c) | (b & c);
      r_lo  <= w_lo[LO_W-1:0];
      r_k2  <= w_lo[LO_W];
      r_s2h <= r_s1[WIDTH-1:LO_W];
      r_c2h <= r_c1[WIDTH-1:LO_W-1];
      r_sum <= {w_hi, r_lo};
    end
  end
endmodule

// File: tb/tb_csa_add3_pipe.sv
// tb_csa_add3_pipe: random scoreboard bench for an 8-bit (default split) and a 16-bit (LO_W=1) instance
module tb_csa_add3_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [7:0] a, b, c;
  logic [15:0] a2, b2, c2;
  logic in_ready, in_ready2, out_valid, out_valid2;
  logic [9:0] sum;
  logic [17:0] sum2;
  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] q8[$];
  logic [17:0] q16[$];
  logic prev_stall = 1'b0;
  logic [9:0] prev_sum;
  logic [17:0] prev_sum2;
  always #5 clk = ~clk;
  csa_add3_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );
  csa_add3_pipe #(.WIDTH(16), .LO_W(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a2), .b(b2), .c(c2), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // inputs change at the falling edge; an accepted triple is scored before the rising edge that takes it
  task automatic drive(input logic v, input logic [15:0] x, y, z, input logic r);
    @(negedge clk);
    in_valid = v;
    a = x[7:0]; b = y[7:0]; c = z[7:0];
    a2 = x; b2 = y; c2 = z;
    out_ready = r;
    #1;
    if (in_valid && in_ready) begin
      q8.push_back(10'(x[7:0]) + 10'(y[7:0]) + 10'(z[7:0]));
      q16.push_back(18'(x) + 18'(y) + 18'(z));
    end
  endtask
  task automatic send_one(input logic [15:0] x, y, z);
    drive(1'b1, x, y, z, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
      #2;
      chk($sformatf("lat_valid_%0d", k), 64'(out_valid), 64'(k == 3));
      if (k == 3) begin
        chk("one_sum8", 64'(sum), 64'(x[7:0]) + 64'(y[7:0]) + 64'(z[7:0]));
        chk("one_sum16", 64'(sum2), 64'(x) + 64'(y) + 64'(z));
      end
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) prev_stall = 1'b0;
      else begin
        chk("in_ready", 64'(in_ready), 64'(!out_valid | out_ready));
        chk("in_ready2", 64'(in_ready2), 64'(!out_valid2 | out_ready));
        chk("valid2", 64'(out_valid2), 64'(out_valid));
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_sum8", 64'(sum), 64'(prev_sum));
          chk("stall_sum16", 64'(sum2), 64'(prev_sum2));
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (q8.size() == 0 || q16.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got output %0h with no expected entry", sum);
          end else begin
            chk("sb_sum8", 64'(sum), 64'(q8.pop_front()));
            chk("sb_sum16", 64'(sum2), 64'(q16.pop_front()));
          end
        end
        prev_stall = out_valid & !out_ready;
        prev_sum = sum;
        prev_sum2 = sum2;
      end
    end
  end
  initial begin
    logic [15:0] cv[5];
    cv[0] = 16'h0000; cv[1] = 16'h0001; cv[2] = 16'hFFFF; cv[3] = 16'h5555; cv[4] = 16'hAAAA;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; a2 = '0; b2 = '0; c2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum8", 64'(sum), 64'd0);
    chk("rst_sum16", 64'(sum2), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    send_one(16'h0012, 16'h0034, 16'h0056);
    send_one(16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int k = 0; k < 5; k++)
          drive(1'b1, cv[i], cv[j], cv[k], 1'b1);
    for (int i = 0; i < 100; i++)
      drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    for (int i = 0; i < 1000; i++)
      drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)));
    for (int i = 0; i < 20 && q8.size() != 0; i++)
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("drain_bp", 64'(q8.size()), 64'd0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    q8.delete();
    q16.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum8", 64'(sum), 64'd0);
    chk("midrst_sum16", 64'(sum2), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
      #2;
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    send_one(16'h00A5, 16'h005A, 16'h00FF);
    chk("final_sb_empty", 64'(q8.size() + q16.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
